// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// FSM encoding, owner tags and default bus widths.
package mem_port_arbiter_pkg;

  localparam int unsigned DEF_ADDR_W = 16;
  localparam int unsigned DEF_DATA_W = 16;

  // Counter widths sized for the legal parameter ranges (MAX_WAIT<=15, RD_LAT<=4)
  localparam int unsigned CNT_W = 4;
  localparam int unsigned LAT_W = 3;

  typedef enum logic {
    ST_READY   = 1'b0,
    ST_RD_WAIT = 1'b1
  } state_t;

  localparam logic OWNER_CPU = 1'b0;
  localparam logic OWNER_LD  = 1'b1;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Saturating count of consecutive cycles the loader requested but was not granted.
// sat tells the arbiter the loader must win its next READY cycle.
module mem_arb_starve_ctr
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && !sat) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign sat = (cnt == CNT_W'(MAX_WAIT));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported instruction/data memory between the CPU and the loader.
// CPU has fixed priority except when the starvation counter has saturated.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W   = DEF_ADDR_W,
  parameter int unsigned DATA_W   = DEF_DATA_W,
  parameter int unsigned RD_LAT   = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  state_t           state;
  state_t           state_nxt;
  logic             owner;
  logic [LAT_W-1:0] lat_cnt;
  logic             cpu_win;
  logic             ld_win;
  logic             rd_issue;
  logic             starve_sat;

  mem_arb_starve_ctr #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clk (CLK),
    .rst (Reset),
    .inc (ld_req && !ld_win),
    .clr (ld_win),
    .sat (starve_sat)
  );

  // Winner selection; grants are suppressed during reset and while a read is in flight
  always_comb begin
    ld_win  = 1'b0;
    cpu_win = 1'b0;
    if (!Reset && state == ST_READY) begin
      ld_win  = ld_req && (!cpu_req || starve_sat);
      cpu_win = cpu_req && !ld_win;
    end
  end

  assign rd_issue = (cpu_win && !cpu_we) || (ld_win && !ld_we);

  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= ST_READY;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_READY: begin
        if (rd_issue) state_nxt = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (lat_cnt == LAT_W'(1)) state_nxt = ST_READY;
      end
      default: state_nxt = ST_READY;
    endcase
  end

  // Read bookkeeping: who owns the outstanding read and how long until its data lands
  always_ff @(posedge CLK) begin
    if (Reset) begin
      owner   <= OWNER_CPU;
      lat_cnt <= '0;
    end else if (rd_issue) begin
      owner   <= ld_win ? OWNER_LD : OWNER_CPU;
      lat_cnt <= LAT_W'(RD_LAT);
    end else if (state == ST_RD_WAIT) begin
      lat_cnt <= lat_cnt - LAT_W'(1);
    end
  end

  always_comb begin
    cpu_gnt    = cpu_win;
    ld_gnt     = ld_win;
    mem_en     = cpu_win || ld_win;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    busy       = !Reset && (state == ST_RD_WAIT);
    cpu_rvalid = 1'b0;
    ld_rvalid  = 1'b0;
    if (cpu_win) begin
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end else if (ld_win) begin
      mem_we    = ld_we;
      mem_addr  = ld_addr;
      mem_wdata = ld_wdata;
    end
    if (busy && lat_cnt == LAT_W'(1)) begin
      cpu_rvalid = (owner == OWNER_CPU);
      ld_rvalid  = (owner == OWNER_LD);
    end
  end

  assign cpu_rdata = mem_rdata;
  assign ld_rdata  = mem_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vector table for the corner cases, then
// randomized protocol-legal traffic checked against a cycle-level reference model.
module tb_mem_port_arbiter;

  localparam int unsigned RD_LAT   = 2;
  localparam int unsigned MAX_WAIT = 4;

  logic        CLK = 1'b0;
  logic        Reset = 1'b1;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0, cpu_wdata = '0;
  logic        ld_req = 1'b0, ld_we = 1'b0;
  logic [15:0] ld_addr = '0, ld_wdata = '0;
  logic        cpu_gnt, cpu_rvalid, ld_gnt, ld_rvalid;
  logic [15:0] cpu_rdata, ld_rdata;
  logic        mem_en, mem_we, busy;
  logic [15:0] mem_addr, mem_wdata, mem_rdata;

  int vectors = 0;
  int miscompares = 0;

  mem_port_arbiter #(
    .ADDR_W (16), .DATA_W (16), .RD_LAT (RD_LAT), .MAX_WAIT (MAX_WAIT)
  ) dut (
    .CLK (CLK), .Reset (Reset),
    .cpu_req (cpu_req), .cpu_we (cpu_we), .cpu_addr (cpu_addr), .cpu_wdata (cpu_wdata),
    .cpu_gnt (cpu_gnt), .cpu_rvalid (cpu_rvalid), .cpu_rdata (cpu_rdata),
    .ld_req (ld_req), .ld_we (ld_we), .ld_addr (ld_addr), .ld_wdata (ld_wdata),
    .ld_gnt (ld_gnt), .ld_rvalid (ld_rvalid), .ld_rdata (ld_rdata),
    .mem_en (mem_en), .mem_we (mem_we), .mem_addr (mem_addr), .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata), .busy (busy)
  );

  always #5 CLK = ~CLK;

  // Memory macro model: 256 words, read data valid RD_LAT cycles after mem_en
  logic [15:0] mem [256];
  logic [15:0] rpipe [2];
  bit          mem_ready = 1'b0;

  function automatic logic [15:0] init_val(int a);
    return (a == 16) ? 16'hBEEF : 16'((a * 257) ^ 16'h5A00);
  endfunction

  always @(posedge CLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_val(i);
      mem_ready <= 1'b1;
    end else if (mem_en && mem_we) begin
      mem[mem_addr[7:0]] <= mem_wdata;
    end
    rpipe[0] <= (mem_en && !mem_we) ? mem[mem_addr[7:0]] : 16'hDEAD;
    rpipe[1] <= rpipe[0];
  end
  assign mem_rdata = rpipe[RD_LAT-1];

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [15:0] ca, cw;
    logic        lreq, lwe;
    logic [15:0] la, lw;
    logic        cg, lg, bsy, crv, lrv;
    logic [15:0] rd;
  } vec_t;

  vec_t        tbl[$];
  logic [15:0] shadow [256];

  function automatic vec_t v(logic rst, logic creq, logic cwe, logic [15:0] ca, logic [15:0] cw,
                             logic lreq, logic lwe, logic [15:0] la, logic [15:0] lw,
                             logic cg, logic lg, logic bsy, logic crv, logic lrv, logic [15:0] rd);
    vec_t r;
    r.rst = rst; r.creq = creq; r.cwe = cwe; r.ca = ca; r.cw = cw;
    r.lreq = lreq; r.lwe = lwe; r.la = la; r.lw = lw;
    r.cg = cg; r.lg = lg; r.bsy = bsy; r.crv = crv; r.lrv = lrv; r.rd = rd;
    return r;
  endfunction

  function automatic logic [54:0] pack(logic cg, logic lg, logic en, logic we, logic bsy,
                                       logic crv, logic lrv, logic [15:0] a, logic [15:0] wd,
                                       logic [15:0] rd);
    return {cg, lg, en, we, bsy, crv, lrv, a, wd, rd};
  endfunction

  // Compares DUT outputs to expected; rdata only matters when a rvalid is expected
  task automatic compare(input string name, input logic cg, input logic lg, input logic bsy,
                         input logic crv, input logic lrv, input logic [15:0] rd,
                         input logic en, input logic we, input logic [15:0] a,
                         input logic [15:0] wd);
    logic [54:0] act, exp_v;
    logic [15:0] rd_act, rd_exp;
    rd_act = cpu_rvalid ? cpu_rdata : (ld_rvalid ? ld_rdata : 16'h0);
    rd_exp = (crv || lrv) ? rd : 16'h0;
    act   = pack(cpu_gnt, ld_gnt, mem_en, mem_we, busy, cpu_rvalid, ld_rvalid,
                 mem_addr, mem_wdata, rd_act);
    exp_v = pack(cg, lg, en, we, bsy, crv, lrv, a, wd, rd_exp);
    vectors++;
    if (act !== exp_v) begin
      miscompares++;
      $display("FAIL %s: got gnt c/l=%b%b en=%b we=%b busy=%b rv c/l=%b%b addr=%h wd=%h rd=%h ; expected %b%b en=%b we=%b busy=%b rv %b%b addr=%h wd=%h rd=%h",
               name, cpu_gnt, ld_gnt, mem_en, mem_we, busy, cpu_rvalid, ld_rvalid,
               mem_addr, mem_wdata, rd_act, cg, lg, en, we, bsy, crv, lrv, a, wd, rd_exp);
    end
  endtask

  // Winner mux expectation shared by both phases
  task automatic winner_fields(input logic cg, input logic lg, output logic en,
                               output logic we, output logic [15:0] a, output logic [15:0] wd);
    en = cg || lg;
    we = 1'b0; a = 16'h0; wd = 16'h0;
    if (cg) begin we = cpu_we; a = cpu_addr; wd = cpu_wdata; end
    else if (lg) begin we = ld_we; a = ld_addr; wd = ld_wdata; end
  endtask

  initial begin
    logic        e_en, e_we;
    logic [15:0] e_a, e_wd;
    // reference model state
    int          starve, rd_rem;
    logic        rd_ld;
    logic [15:0] rd_data;
    logic        c_pend, c_we, c_wait, l_pend, l_we, l_wait, rst;
    logic [15:0] c_a, c_wd, l_a, l_wd;
    logic        e_cg, e_lg, e_bsy, e_crv, e_lrv;
    logic [15:0] e_rd;

    for (int i = 0; i < 256; i++) shadow[i] = init_val(i);

    // reset with both requesting, then first CPU read of 0xBEEF while loader waits
    tbl.push_back(v(1, 1,0,16'h10,16'h0,    1,1,16'h30,16'h5A5A, 0,0,0,0,0,16'h0));
    tbl.push_back(v(1, 1,0,16'h10,16'h0,    1,1,16'h30,16'h5A5A, 0,0,0,0,0,16'h0));
    tbl.push_back(v(0, 1,0,16'h10,16'h0,    1,1,16'h30,16'h5A5A, 1,0,0,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     1,1,16'h30,16'h5A5A, 0,0,1,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     1,1,16'h30,16'h5A5A, 0,0,1,1,0,16'hBEEF));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     1,1,16'h30,16'h5A5A, 0,1,0,0,0,16'h0));
    // back-to-back CPU writes and readback
    tbl.push_back(v(0, 1,1,16'h1,16'h1111,  0,0,16'h0,16'h0, 1,0,0,0,0,16'h0));
    tbl.push_back(v(0, 1,1,16'h2,16'h2222,  0,0,16'h0,16'h0, 1,0,0,0,0,16'h0));
    tbl.push_back(v(0, 1,1,16'h3,16'h3333,  0,0,16'h0,16'h0, 1,0,0,0,0,16'h0));
    tbl.push_back(v(0, 1,0,16'h1,16'h0,     0,0,16'h0,16'h0, 1,0,0,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     0,0,16'h0,16'h0, 0,0,1,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     0,0,16'h0,16'h0, 0,0,1,1,0,16'h1111));
    tbl.push_back(v(0, 1,0,16'h3,16'h0,     0,0,16'h0,16'h0, 1,0,0,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     0,0,16'h0,16'h0, 0,0,1,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     0,0,16'h0,16'h0, 0,0,1,1,0,16'h3333));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     1,0,16'h30,16'h0, 0,1,0,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     0,0,16'h0,16'h0, 0,0,1,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     0,0,16'h0,16'h0, 0,0,1,0,1,16'h5A5A));
    // starvation: CPU writes every cycle, loader wins on the 5th cycle, twice
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0, 1,1,16'(16'h50 + i),16'(16'h5050 + i), 1,1,16'h40,16'h4444, 1,0,0,0,0,16'h0));
    tbl.push_back(v(0, 1,1,16'h54,16'h5054, 1,1,16'h40,16'h4444, 0,1,0,0,0,16'h0));
    for (int i = 0; i < 4; i++)
      tbl.push_back(v(0, 1,1,16'(16'h54 + i),16'(16'h5054 + i), 1,1,16'h41,16'h4141, 1,0,0,0,0,16'h0));
    tbl.push_back(v(0, 1,1,16'h58,16'h5058, 1,1,16'h41,16'h4141, 0,1,0,0,0,16'h0));
    tbl.push_back(v(0, 1,1,16'h58,16'h5058, 0,0,16'h0,16'h0,     1,0,0,0,0,16'h0));
    // both request reads in the same cycle
    tbl.push_back(v(0, 1,0,16'h10,16'h0,    1,0,16'h40,16'h0, 1,0,0,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     1,0,16'h40,16'h0, 0,0,1,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     1,0,16'h40,16'h0, 0,0,1,1,0,16'hBEEF));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     1,0,16'h40,16'h0, 0,1,0,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     0,0,16'h0,16'h0,  0,0,1,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     0,0,16'h0,16'h0,  0,0,1,0,1,16'h4444));
    // loader read aborted by reset, then CPU write and readback of the starved write
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     1,0,16'h41,16'h0, 0,1,0,0,0,16'h0));
    tbl.push_back(v(1, 0,0,16'h0,16'h0,     0,0,16'h0,16'h0,  0,0,0,0,0,16'h0));
    tbl.push_back(v(0, 1,1,16'h60,16'h6666, 0,0,16'h0,16'h0,  1,0,0,0,0,16'h0));
    tbl.push_back(v(0, 1,0,16'h41,16'h0,    0,0,16'h0,16'h0,  1,0,0,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     0,0,16'h0,16'h0,  0,0,1,0,0,16'h0));
    tbl.push_back(v(0, 0,0,16'h0,16'h0,     0,0,16'h0,16'h0,  0,0,1,1,0,16'h4141));

    foreach (tbl[i]) begin
      @(negedge CLK);
      Reset = tbl[i].rst;
      cpu_req = tbl[i].creq; cpu_we = tbl[i].cwe; cpu_addr = tbl[i].ca; cpu_wdata = tbl[i].cw;
      ld_req = tbl[i].lreq;  ld_we = tbl[i].lwe;  ld_addr = tbl[i].la;  ld_wdata = tbl[i].lw;
      #1;
      winner_fields(tbl[i].cg, tbl[i].lg, e_en, e_we, e_a, e_wd);
      compare($sformatf("vec%0d", i), tbl[i].cg, tbl[i].lg, tbl[i].bsy, tbl[i].crv,
              tbl[i].lrv, tbl[i].rd, e_en, e_we, e_a, e_wd);
      if (e_en && e_we) shadow[e_a[7:0]] = e_wd;
    end

    // Randomized phase: requesters obey the hold-until-grant / wait-for-rvalid protocol
    starve = 0; rd_rem = 0; rd_ld = 1'b0; rd_data = 16'h0;
    c_pend = 1'b0; c_wait = 1'b0; c_we = 1'b0; c_a = 16'h0; c_wd = 16'h0;
    l_pend = 1'b0; l_wait = 1'b0; l_we = 1'b0; l_a = 16'h0; l_wd = 16'h0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge CLK);
      rst = (c == 0) || ($urandom_range(0, 299) == 0);
      if (!c_pend && !c_wait && $urandom_range(0, 99) < 60) begin
        c_pend = 1'b1; c_we = 1'($urandom); c_a = 16'($urandom_range(0, 255)); c_wd = 16'($urandom);
      end
      if (!l_pend && !l_wait && $urandom_range(0, 99) < 40) begin
        l_pend = 1'b1; l_we = 1'($urandom); l_a = 16'($urandom_range(0, 255)); l_wd = 16'($urandom);
      end
      Reset = rst;
      cpu_req = c_pend; cpu_we = c_pend ? c_we : 1'($urandom);
      cpu_addr = c_pend ? c_a : 16'($urandom); cpu_wdata = c_pend ? c_wd : 16'($urandom);
      ld_req = l_pend; ld_we = l_pend ? l_we : 1'($urandom);
      ld_addr = l_pend ? l_a : 16'($urandom); ld_wdata = l_pend ? l_wd : 16'($urandom);
      #1;
      e_cg = 1'b0; e_lg = 1'b0; e_bsy = 1'b0; e_crv = 1'b0; e_lrv = 1'b0; e_rd = 16'h0;
      if (!rst) begin
        if (rd_rem > 0) begin
          e_bsy = 1'b1;
          if (rd_rem == 1) begin
            e_lrv = rd_ld; e_crv = !rd_ld; e_rd = rd_data;
          end
        end else begin
          e_lg = l_pend && (!c_pend || starve == int'(MAX_WAIT));
          e_cg = c_pend && !e_lg;
        end
      end
      winner_fields(e_cg, e_lg, e_en, e_we, e_a, e_wd);
      compare($sformatf("rand%0d", c), e_cg, e_lg, e_bsy, e_crv, e_lrv, e_rd,
              e_en, e_we, e_a, e_wd);
      if (rst) begin
        starve = 0; rd_rem = 0; c_wait = 1'b0; l_wait = 1'b0;
      end else begin
        if (rd_rem > 0) rd_rem--;
        if (e_lg) starve = 0;
        else if (l_pend && starve < int'(MAX_WAIT)) starve++;
        if (e_en) begin
          if (e_we) shadow[e_a[7:0]] = e_wd;
          else begin
            rd_rem = int'(RD_LAT); rd_ld = e_lg; rd_data = shadow[e_a[7:0]];
          end
        end
        if (e_crv) c_wait = 1'b0;
        if (e_lrv) l_wait = 1'b0;
        if (e_cg) begin c_pend = 1'b0; c_wait = !c_we; end
        if (e_lg) begin l_pend = 1'b0; l_wait = !l_we; end
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-ported unified instruction/data memory between two requesters: the multicycle CPU control path (fetch, lw, sw) and the program loader/debug port.
- Sits between both requesters and the memory macro; owns every mem_* signal.
- CPU has fixed priority. A saturating starvation counter guarantees the loader a slot.
- One outstanding read at a time.

Parameters:
- ADDR_W, 16, address width in bits.
- DATA_W, 16, data width in bits.
- RD_LAT, 2, memory read latency in cycles (legal range 1..4).
- MAX_WAIT, 4, number of consecutive lost cycles after which the loader beats the CPU (legal range 1..15).

Ports:
- CLK  in  1  system clock.
- Reset  in  1  synchronous, active-high reset.
- cpu_req  in  1  CPU access request; held with its fields until cpu_gnt.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  CPU address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_gnt  out  1  one-cycle grant; the access is issued in this cycle.
- cpu_rvalid  out  1  CPU read data valid.
- cpu_rdata  out  DATA_W  CPU read data.
- ld_req, ld_we, ld_addr, ld_wdata, ld_gnt, ld_rvalid, ld_rdata  same directions, widths and meanings for the loader.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data; valid RD_LAT cycles after the mem_en cycle.
- busy  out  1  high while a read is outstanding.

Behaviour:
- Reset values (the clock edge with Reset high):
  - state = READY, starve_cnt = 0, owner = CPU, lat_cnt = 0.
  - All gnt, rvalid, mem_en, mem_we and busy outputs are 0.
- Reset mid-read: the outstanding read is discarded and no rvalid ever follows it.
- FSM has two states, READY and RD_WAIT.
- READY: winner is chosen combinationally from the requests in the current cycle.
  - Loader wins if ld_req=1 and (cpu_req=0 or starve_cnt==MAX_WAIT).
  - Otherwise CPU wins if cpu_req=1.
  - Winner: gnt=1 and mem_en=1 in the same cycle; mem_we/addr/wdata are muxed from the winner. Grant latency is 0 cycles from the request.
  - Write: completes in the grant cycle; state stays READY, so back-to-back writes can be granted every cycle.
  - Read: state goes to RD_WAIT, owner is recorded, lat_cnt is loaded with RD_LAT.
- RD_WAIT:
  - All gnt and mem_en are 0; busy=1.
  - lat_cnt decrements each cycle.
  - In the cycle lat_cnt==1, owner's rvalid=1 for exactly one cycle; the next state is READY.
  - rvalid therefore occurs in cycle G+RD_LAT, and the earliest next grant is G+RD_LAT+1.
- cpu_rdata and ld_rdata are both wired to mem_rdata; only rvalid qualifies them.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) on every cycle where ld_req=1 and ld_gnt=0, including RD_WAIT cycles.
  - Clears on ld_gnt.
  - Held when ld_req=0.
- Requesters must hold req and fields stable until gnt. Dropping a request early is a protocol violation: the arbiter samples only the current cycle and does not need to flag it.
- A requester may assert its next req in the cycle after its gnt (writes) or in the cycle after its rvalid (reads).
- Unused mux outputs drive 0 (no X onto the memory bus).

Decomposition:
- Shared package: FSM state encoding (READY, RD_WAIT), OWNER_CPU/OWNER_LD constants, default ADDR_W/DATA_W.
- One sub-module is natural: mem_arb_starve_ctr (saturating counter with inc/clr/sat outputs).
- FSM and muxes stay in mem_port_arbiter.

Test Plan (RD_LAT=2, MAX_WAIT=4):
- Reset held 2 cycles with cpu_req=ld_req=1 -> no gnt, mem_en or rvalid during reset; first cycle after release: cpu_gnt=1, ld_gnt=0.
- CPU read of 0x0010 (memory holds 0xBEEF), grant at cycle 0 -> cycle 0: mem_en=1, mem_we=0, mem_addr=0x0010; busy=1 in cycles 1-2; cpu_rvalid=1 with cpu_rdata=0xBEEF in cycle 2 only; ld_rvalid stays 0.
- CPU writes 0x0001/0x1111, 0x0002/0x2222, 0x0003/0x3333 back-to-back -> cpu_gnt and mem_we high in 3 consecutive cycles; readback returns those values.
- CPU writes every cycle with ld_req held from cycle 0 -> cpu wins cycles 0-3; ld_gnt=1 in cycle 4; starve_cnt reads 0 in cycle 5; CPU wins again in cycle 5.
- Both request reads in cycle 0 -> cpu_gnt cycle 0, cpu_rvalid cycle 2; ld_gnt cycle 3, ld_rvalid cycle 5.
- Loader read granted at cycle G, Reset=1 at G+1 -> no ld_rvalid at G+2; busy=0 and READY after reset; a CPU request is granted in the first cycle after release.
